dmem_arbiter: RTL and testbench

//  Two-port arbiter/sequencer in front of the single-port data_mem (8-bit addr,

---
 rtl/dmem_arbiter.sv | 138 +++++++++++++
 tb/tb_dmem_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port data memory.
// Define DMEM_ARB_FIXED_PRIO_EN to make port 0 win every tie instead of round-robin.
module dmem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_i,
  input  logic          req1_i,
  input  logic          we0_i,
  input  logic          we1_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [DW-1:0] wdata0_i,
  input  logic [DW-1:0] wdata1_i,
  output logic          ack0_o,
  output logic          ack1_o,
  output logic [DW-1:0] rdata0_o,
  output logic [DW-1:0] rdata1_o,
  output logic          busy_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic          mem_wren_o,
  input  logic [DW-1:0] mem_rdata_i
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  logic [0:0]    state_q, state_d;
  logic          sel_q, sel_d;
  logic          last_q, last_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  logic          elig0, elig1, anyElig, grant;
  logic          reqSel, weSel;
  logic [AW-1:0] addrSel;
  logic [DW-1:0] wdataSel;

  // A port acked this cycle is masked so a still-high req is not granted twice.
  always_comb begin
    elig0   = req0_i & ~ack0_q;
    elig1   = req1_i & ~ack1_q;
    anyElig = elig0 | elig1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    grant = ~elig0;
`else
    if (elig0 && elig1) begin
      grant = ~last_q;
    end else begin
      grant = ~elig0;
    end
`endif
  end

  always_comb begin
    reqSel   = sel_q ? req1_i   : req0_i;
    weSel    = sel_q ? we1_i    : we0_i;
    addrSel  = sel_q ? addr1_i  : addr0_i;
    wdataSel = sel_q ? wdata1_i : wdata0_i;
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    last_d   = last_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      ST_IDLE: begin
        if (anyElig) begin
          sel_d   = grant;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_d = ST_IDLE;
        last_d  = sel_q;
        // A request dropped during the access cycle is a cancel: no ack, no data.
        if (reqSel) begin
          if (sel_q) begin
            ack1_d = 1'b1;
            if (!weSel) rdata1_d = mem_rdata_i;
          end else begin
            ack0_d = 1'b1;
            if (!weSel) rdata0_d = mem_rdata_i;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sel_q    <= 1'b0;
      last_q   <= 1'b1;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Memory drive is decoded from state so reset forces wren high immediately.
  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wren_o  = 1'b1;
    if (state_q == ST_ACCESS) begin
      mem_addr_o  = addrSel;
      mem_wdata_o = wdataSel;
      mem_wren_o  = ~(reqSel & weSel);
    end
  end

  assign ack0_o   = ack0_q;
  assign ack1_o   = ack1_q;
  assign rdata0_o = rdata0_q;
  assign rdata1_o = rdata1_q;
  assign busy_o   = (state_q == ST_ACCESS);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural data memory and a scoreboard
// of expected acks/read data.
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, we0, we1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       ack0, ack1, busy, memWren;
  logic [7:0] rdata0, rdata1, memAddr, memWdata, memRdata;

  logic       preloadEn;
  logic [7:0] preloadAddr, preloadData;
  logic [7:0] mem    [256];
  logic [7:0] refMem [256];

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int         port;
    logic       isRead;
    logic [7:0] data;
  } expT;
  expT expQ[$];

  dmem_arbiter #(.AW(8), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .ack0_o(ack0), .ack1_o(ack1), .rdata0_o(rdata0), .rdata1_o(rdata1),
    .busy_o(busy), .mem_addr_o(memAddr), .mem_wdata_o(memWdata),
    .mem_wren_o(memWren), .mem_rdata_i(memRdata)
  );

  always #5 clk = ~clk;

  // Single-port memory: async read, write on posedge while wren is low.
  always @(posedge clk) begin
    if (preloadEn) mem[preloadAddr] <= preloadData;
    else if (memWren == 1'b0) mem[memAddr] <= memWdata;
  end
  assign memRdata = mem[memAddr];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int port, input logic req, input logic we,
                               input logic [7:0] addr, input logic [7:0] wdata);
    if (port == 0) begin
      req0 = req; we0 = we; addr0 = addr; wdata0 = wdata;
    end else begin
      req1 = req; we1 = we; addr1 = addr; wdata1 = wdata;
    end
  endtask

  task automatic pushExp(input int port, input logic isWrite, input logic [7:0] addr,
                         input logic [7:0] wdata);
    expT e;
    e.port   = port;
    e.isRead = ~isWrite;
    e.data   = isWrite ? 8'h00 : refMem[addr];
    expQ.push_back(e);
    if (isWrite) refMem[addr] = wdata;
  endtask

  task automatic scoreboardPop();
    expT e;
    checkOutput("sbUnderflow", (expQ.size() == 0) ? 1 : 0, 0);
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      checkOutput("ackBoth", {31'd0, ack0 & ack1}, 0);
      checkOutput("ackPort", ack1 ? 1 : 0, e.port);
      if (e.isRead) checkOutput("rdata", (e.port == 1) ? rdata1 : rdata0, e.data);
    end
  endtask

  task automatic runTxn(input int port, input logic isWrite, input logic [7:0] addr,
                        input logic [7:0] wdata);
    int  n   = 0;
    bit  got = 0;
    pushExp(port, isWrite, addr, wdata);
    applyStimulus(port, 1'b1, isWrite, addr, wdata);
    while (!got && n < 10) begin
      tick();
      n++;
      if (ack0 || ack1) got = 1;
    end
    if (!got) checkOutput("ackTimeout", 0, 1);
    else begin
      checkOutput("ackLatency", n, 2);
      scoreboardPop();
    end
    applyStimulus(port, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int acks;
    int n;
    rst = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    preloadEn = 1'b0; preloadAddr = 0; preloadData = 0;

    // Preload memory while held in reset.
    for (int i = 0; i < 5; i++) begin
      preloadEn = 1'b1;
      case (i)
        0: begin preloadAddr = 8'h00; preloadData = 8'h11; end
        1: begin preloadAddr = 8'h01; preloadData = 8'h22; end
        2: begin preloadAddr = 8'h10; preloadData = 8'h55; end
        3: begin preloadAddr = 8'h20; preloadData = 8'h66; end
        default: begin preloadAddr = 8'h05; preloadData = 8'h00; end
      endcase
      refMem[preloadAddr] = preloadData;
      tick();
    end
    preloadEn = 1'b0;

    $display("[TB] reset state");
    checkOutput("rstAck0", {31'd0, ack0}, 0);
    checkOutput("rstAck1", {31'd0, ack1}, 0);
    checkOutput("rstRdata0", rdata0, 0);
    checkOutput("rstRdata1", rdata1, 0);
    checkOutput("rstWren", {31'd0, memWren}, 1);
    checkOutput("rstBusy", {31'd0, busy}, 0);
    checkOutput("rstMemAddr", memAddr, 0);
    checkOutput("rstMemWdata", memWdata, 0);
    rst = 1'b0;
    tick();
    checkOutput("postRstBusy", {31'd0, busy}, 0);
    checkOutput("postRstWren", {31'd0, memWren}, 1);

    $display("[TB] single write then read-back");
    pushExp(0, 1'b1, 8'h05, 8'h21);
    applyStimulus(0, 1'b1, 1'b1, 8'h05, 8'h21);
    #1;
    checkOutput("wrWrenIdle", {31'd0, memWren}, 1);
    tick();
    checkOutput("wrBusy", {31'd0, busy}, 1);
    checkOutput("wrWrenAccess", {31'd0, memWren}, 0);
    checkOutput("wrMemAddr", memAddr, 8'h05);
    checkOutput("wrMemWdata", memWdata, 8'h21);
    tick();
    checkOutput("wrAck0", {31'd0, ack0}, 1);
    scoreboardPop();
    checkOutput("wrWrenAfter", {31'd0, memWren}, 1);
    checkOutput("wrBusyAfter", {31'd0, busy}, 0);
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    checkOutput("wrAckPulse", {31'd0, ack0}, 0);
    runTxn(0, 1'b0, 8'h05, 8'h00);

    $display("[TB] both ports held, round-robin");
    doReset();
    checkOutput("rrRdata0Cleared", rdata0, 0);
    pushExp(0, 1'b0, 8'h00, 8'h00);
    pushExp(1, 1'b0, 8'h01, 8'h00);
    pushExp(0, 1'b0, 8'h00, 8'h00);
    pushExp(1, 1'b0, 8'h01, 8'h00);
    applyStimulus(0, 1'b1, 1'b0, 8'h00, 8'h00);
    applyStimulus(1, 1'b1, 1'b0, 8'h01, 8'h00);
    acks = 0;
    n = 0;
    while (acks < 4 && n < 20) begin
      tick();
      n++;
      if (ack0 || ack1) begin
        scoreboardPop();
        acks++;
      end
    end
    checkOutput("rrAckCount", acks, 4);
    checkOutput("rrCycles", n, 8);
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    checkOutput("rrIdleBusy", {31'd0, busy}, 0);
    tick();
    checkOutput("rrIdleAcks", {30'd0, ack1, ack0}, 0);

    $display("[TB] cancelled write on port 1");
    applyStimulus(1, 1'b1, 1'b1, 8'h10, 8'h87);
    tick();
    checkOutput("cxWrenLow", {31'd0, memWren}, 0);
    applyStimulus(1, 1'b0, 1'b1, 8'h10, 8'h87);
    #1;
    checkOutput("cxWrenHigh", {31'd0, memWren}, 1);
    tick();
    checkOutput("cxNoAck1", {31'd0, ack1}, 0);
    checkOutput("cxBusy", {31'd0, busy}, 0);
    tick();
    runTxn(0, 1'b0, 8'h10, 8'h00);

    $display("[TB] reset during write access");
    applyStimulus(0, 1'b1, 1'b1, 8'h20, 8'hA9);
    tick();
    checkOutput("rmWrenLow", {31'd0, memWren}, 0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rmWrenAsync", {31'd0, memWren}, 1);
    checkOutput("rmBusyAsync", {31'd0, busy}, 0);
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();
    #2;
    rst = 1'b0;
    tick();
    checkOutput("rmNoAck0", {31'd0, ack0}, 0);
    runTxn(0, 1'b0, 8'h20, 8'h00);

    $display("[TB] request held across ack");
    pushExp(0, 1'b0, 8'h05, 8'h00);
    pushExp(0, 1'b0, 8'h05, 8'h00);
    applyStimulus(0, 1'b1, 1'b0, 8'h05, 8'h00);
    tick();
    checkOutput("hdBusyN1", {31'd0, busy}, 1);
    tick();
    checkOutput("hdAckN2", {31'd0, ack0}, 1);
    scoreboardPop();
    tick();
    checkOutput("hdBusyN3", {31'd0, busy}, 0);
    checkOutput("hdAckN3", {31'd0, ack0}, 0);
    tick();
    checkOutput("hdBusyN4", {31'd0, busy}, 1);
    tick();
    checkOutput("hdAckN5", {31'd0, ack0}, 1);
    scoreboardPop();
    applyStimulus(0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    checkOutput("hdQuiet", {30'd0, busy, ack0}, 0);
    checkOutput("sbDrained", expQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
